// File: rtl/wb_stage_buf_pkg.sv
// Shared definitions for the MEM->WB stage buffer.
// - XLEN_DEF / RD_W_DEF : default data and register-index widths
// - wb_bundle_t         : writeback bundle layout at the default widths
// - buf_state_t         : occupancy states of the stage buffer
// - bundle_width()      : flat bundle width for arbitrary widths; the top
//                         packs fields in the same order as wb_bundle_t
package wb_stage_buf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic [RD_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0] result;
        logic [XLEN_DEF-1:0] read_data;
    } wb_bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    function automatic int bundle_width(input int xlen, input int rd_w);
        return 2 + rd_w + 2 * xlen;
    endfunction

endpackage

// File: rtl/wb_stage_buf_skid_entry.sv
// wb_skid_entry: one valid bit plus a flat writeback bundle register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears valid and payload)
//   i_load    : capture i_d and set valid
//   i_clear   : clear valid only; payload is held (wins over i_load)
//   i_d       : bundle to capture
//   o_valid   : entry holds a live bundle
//   o_d       : stored bundle
module wb_skid_entry #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_d
);

    logic         r_valid;
    logic [W-1:0] r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_d     <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_d     <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_d     = r_d;

endmodule

// File: rtl/wb_stage_buf.sv
// wb_stage_buf: MEM->WB pipeline stage with valid/ready handshake, optional
// 2-entry skid buffer, flush, x0 write suppression and resolved writeback data.
// Ports:
//   clk, rst, flush                   : clock, sync active-high reset, drop all entries
//   in_valid / in_ready               : upstream handshake
//   in_reg_write, in_mem_to_reg, in_rd,
//   in_result, in_read_data           : incoming writeback bundle
//   out_valid / out_ready             : downstream handshake (head entry)
//   out_reg_write                     : head write enable, x0-suppressed, gated by out_valid
//   out_rd, out_wb_data               : head destination and selected writeback data
//   out_result, out_read_data         : raw head fields for forwarding/debug
//
// state    | meaning
// ST_EMPTY | no entries held, in_ready=1
// ST_ONE   | head valid, skid empty, in_ready=1
// ST_TWO   | head and skid valid, in_ready=0 (SKID_EN=1 only)
module wb_stage_buf
    import wb_stage_buf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int SKID_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic            in_mem_to_reg,
    input  logic [RD_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_read_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_reg_write,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_wb_data,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_read_data
);

    localparam int BW = bundle_width(XLEN, RD_W);

    buf_state_t     r_state;
    logic [BW-1:0]  w_in_bundle;
    logic [BW-1:0]  w_head_d;
    logic [BW-1:0]  w_head_q;
    logic [BW-1:0]  w_skid_q;
    logic           w_head_valid;
    logic           w_skid_valid;
    logic           w_in_rw;
    logic           w_accept;
    logic           w_release;
    logic           w_head_load;
    logic           w_head_clr;
    logic           w_skid_load;
    logic           w_skid_clr;

    // Write enable to x0 is dropped at capture so the stored bundle is already clean.
    assign w_in_rw     = in_reg_write && (in_rd != '0);
    assign w_in_bundle = {w_in_rw, in_mem_to_reg, in_rd, in_result, in_read_data};

    assign w_accept  = in_valid && in_ready && !flush;
    assign w_release = w_head_valid && out_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            // Registered-only ready: no out_ready -> in_ready path.
            assign in_ready = !w_skid_valid;
            wb_skid_entry #(.W(BW)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clr),
                .i_d     (w_in_bundle),
                .o_valid (w_skid_valid),
                .o_d     (w_skid_q)
            );
        end else begin : g_single
            assign in_ready     = !w_head_valid || out_ready;
            assign w_skid_valid = 1'b0;
            assign w_skid_q     = '0;
        end
    endgenerate

    always_comb begin
        w_head_load = 1'b0;
        w_head_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        w_head_d    = w_in_bundle;
        if (flush) begin
            w_head_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_head_load = w_accept;
                ST_ONE: begin
                    if (w_accept && w_release) w_head_load = 1'b1;
                    else if (w_accept)         w_skid_load = 1'b1;
                    else if (w_release)        w_head_clr  = 1'b1;
                end
                ST_TWO: begin
                    // Skid entry moves forward; upstream is stalled this cycle.
                    if (w_release) begin
                        w_head_load = 1'b1;
                        w_head_d    = w_skid_q;
                        w_skid_clr  = 1'b1;
                    end
                end
                default: begin
                    w_head_clr = 1'b1;
                    w_skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_release)      r_state <= ST_TWO;
                    else if (!w_accept && w_release) r_state <= ST_EMPTY;
                end
                ST_TWO:   if (w_release) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    wb_skid_entry #(.W(BW)) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_head_load),
        .i_clear (w_head_clr),
        .i_d     (w_head_d),
        .o_valid (w_head_valid),
        .o_d     (w_head_q)
    );

    assign out_valid     = w_head_valid;
    assign out_reg_write = w_head_valid && w_head_q[BW-1];
    assign out_rd        = w_head_q[BW-3 -: RD_W];
    assign out_result    = w_head_q[2*XLEN-1:XLEN];
    assign out_read_data = w_head_q[XLEN-1:0];
    assign out_wb_data   = w_head_q[BW-2] ? w_head_q[XLEN-1:0] : w_head_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_wb_stage_buf.sv
module tb_wb_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic        in_mem_to_reg = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic [31:0] in_read_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_reg_write;
    logic [4:0]  out_rd;
    logic [31:0] out_wb_data;
    logic [31:0] out_result;
    logic [31:0] out_read_data;

    always #5 clk = ~clk;

    wb_stage_buf dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_rd         (in_rd),
        .in_result     (in_result),
        .in_read_data  (in_read_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_reg_write (out_reg_write),
        .out_rd        (out_rd),
        .out_wb_data   (out_wb_data),
        .out_result    (out_result),
        .out_read_data (out_read_data)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic [31:0] res;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One cycle of stimulus. Expected writeback is queued when the beat is accepted.
    task automatic cyc(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] rdata,
                       input logic ordy, input logic fl, input logic rs, output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = rd;
        in_result = res; in_read_data = rdata; out_ready = ordy; flush = fl; rst = rs;
        #1;
        acc = v && in_ready && !fl && !rs;
        if (acc) begin
            e.we    = rw && (rd != 5'd0);
            e.rd    = rd;
            e.wb    = m2r ? rdata : res;
            e.res   = res;
            e.rdata = rdata;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy, input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, ordy, 1'b0, 1'b0, a);
    endtask

    // Present a beat until taken, holding out_ready at ordy; bounded.
    task automatic send(input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] rdata, input logic ordy);
        logic a;
        int   k;
        a = 1'b0;
        k = 0;
        while (!a && k < 20) begin
            cyc(1'b1, rw, m2r, rd, res, rdata, ordy, 1'b0, 1'b0, a);
            k++;
        end
        if (!a) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: model occupancy and compare head against the scoreboard on release.
    int   occ = 0;
    logic rst_prev = 1'b1;
    initial begin
        exp_t e;
        logic rel, acc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
                chk("in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
                if (rst_prev) begin
                    chk("rst_rd", {27'd0, out_rd}, 32'd0);
                    chk("rst_wb_data", out_wb_data, 32'd0);
                    chk("rst_result", out_result, 32'd0);
                    chk("rst_read_data", out_read_data, 32'd0);
                    chk("rst_reg_write", {31'd0, out_reg_write}, 32'd0);
                end
                if (!out_valid) chk("idle_reg_write", {31'd0, out_reg_write}, 32'd0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", {27'd0, out_rd}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                        chk("wb_data", out_wb_data, e.wb);
                        chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.we});
                        chk("result", out_result, e.res);
                        chk("read_data", out_read_data, e.rdata);
                    end
                end
            end
            rel = (occ > 0) && out_ready;
            acc = in_valid && (occ < 2) && !flush && !rst;
            if (rst || flush) begin
                occ = 0;
                q.delete();
            end else begin
                occ = occ + (acc ? 1 : 0) - (rel ? 1 : 0);
            end
            rst_prev = rst;
        end
    end

    initial begin
        logic a;
        logic [4:0] r;
        idle(1'b1, 2);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, a);

        // single beat, load select, x0 suppression
        send(1'b1, 1'b0, 5'd5, 32'h1234, 32'hDEAD, 1'b1);
        idle(1'b1, 2);
        send(1'b1, 1'b1, 5'd7, 32'h10, 32'hCAFEBABE, 1'b1);
        idle(1'b1, 1);
        send(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1);
        idle(1'b1, 2);

        // backpressure: A, B fill the buffer, C is held upstream, then drain
        send(1'b1, 1'b0, 5'd1, 32'h1, 32'hA, 1'b0);
        send(1'b1, 1'b0, 5'd2, 32'h2, 32'hB, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 5'd3, 32'h3, 32'hC, 1'b0, 1'b0, 1'b0, a);
        send(1'b1, 1'b0, 5'd3, 32'h3, 32'hC, 1'b1);
        idle(1'b1, 3);

        // flush while full with beat D presented
        send(1'b1, 1'b0, 5'd4, 32'h44, 32'h0, 1'b0);
        send(1'b1, 1'b0, 5'd6, 32'h66, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'd13, 32'hD, 32'hD, 1'b0, 1'b1, 1'b0, a);
        idle(1'b1, 3);

        // reset mid-stream, then a fresh beat
        send(1'b1, 1'b0, 5'd8, 32'h88, 32'h0, 1'b0);
        send(1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, a);
        send(1'b1, 1'b1, 5'd10, 32'hAA, 32'h5555AAAA, 1'b1);
        idle(1'b1, 2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
            cyc($urandom_range(3) != 0, 1'($urandom), 1'($urandom), r, $urandom, $urandom,
                $urandom_range(9) < 6, $urandom_range(39) == 0, $urandom_range(79) == 0, a);
        end
        idle(1'b1, 6);
        chk("drain_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
